rl_lj_filter_arbiter: RTL and testbench
=======================================

RL_LJ_FILTER_ARBITER -- requirements
Module: rl_lj_filter_arbiter

Interface
REQ-001 NUM_FILTER, 4, number of filter buffers sharing one force evaluation pipeline.
REQ-002 ARBITER_MSB, 8, one-hot value of the highest filter index, equal to 2^(NUM_FILTER-1).
REQ-003 FILTER_SEL_WIDTH, 2, width of the selected-filter index, equal to log2(NUM_FILTER).
REQ-004 FORCE_PIPE_LATENCY, 17, cycles from pipe_input_valid to the corresponding forceoutput_valid.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  run request, level input; only a 0->1 transition is acted on.
REQ-008 pair_gen_done  in  1  upstream pair generation has issued its last candidate to the filters.
REQ-009 filter_req  in  NUM_FILTER  bit i = filter buffer i is non-empty.
REQ-010 pipe_stall  in  1  force pipeline cannot accept input this cycle.
REQ-011 filter_grant  out  NUM_FILTER  one-hot pop strobe to the filter buffers; all zero when there is no grant.
REQ-012 pipe_input_valid  out  1  registered; the buffer data popped in the previous cycle is on the pipeline input.
REQ-013 pipe_sel  out  FILTER_SEL_WIDTH  registered index of the filter whose data is on the pipeline input.
REQ-014 issue_count  out  32  number of grants issued since the last start.
REQ-015 busy  out  1  high in states RUN and DRAIN.
REQ-016 done  out  1  level; high in state DONE.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-018 The FSM SHALL make these transitions:
- IDLE->RUN on a start rising edge.
- RUN->DRAIN when pair_gen_done has been latched and filter_req==0.
- DRAIN->DONE when the drain counter equals FORCE_PIPE_LATENCY-1.
- DONE->RUN on a start rising edge.
REQ-019 The start edge SHALL be detected against a registered copy of start; a level held high SHALL NOT retrigger.
REQ-020 pair_gen_done SHALL be latched into a sticky flag in RUN; the flag is cleared on entry to RUN.
REQ-021 Grant rule: in RUN with pipe_stall=0 and filter_req!=0, exactly one filter_grant bit SHALL be asserted in the same cycle.
- The winner is the first requester at or after the rotating one-hot priority pointer, searching upward with wrap from ARBITER_MSB to bit 0.
REQ-022 After a grant to filter i, the pointer SHALL become one-hot (i+1) mod NUM_FILTER; with no grant, the pointer SHALL hold.
REQ-023 filter_grant SHALL be all zero in IDLE, DRAIN and DONE, and whenever pipe_stall=1.
REQ-024 pipe_input_valid and pipe_sel SHALL equal the previous cycle's grant-valid and grant index (1-cycle buffer read latency).
REQ-025 issue_count SHALL increment by 1 per grant, clear to 0 on the start edge, and saturate at 32'hFFFFFFFF.
REQ-026 The drain counter SHALL clear on DRAIN entry and increment each DRAIN cycle with pipe_stall=0; it SHALL freeze while pipe_stall=1.
REQ-027 If filter_req becomes non-zero in DRAIN, the FSM SHALL return to RUN; the latched done flag SHALL be kept.
REQ-028 If pair_gen_done is already high when filter_req first reaches 0, DRAIN SHALL be entered on the next edge.
REQ-029 A start edge in RUN or DRAIN SHALL be ignored.
REQ-030 A single requester SHALL be granted every non-stalled cycle; with all NUM_FILTER requesting continuously, grants SHALL cycle 0,1,2,3,0...

Reset
REQ-031 On rst=0, asynchronously:
- state=IDLE, pointer=1 (filter 0 highest priority);
- filter_grant=0, pipe_input_valid=0, pipe_sel=0;
- issue_count=0, busy=0, done=0;
- drain counter=0, done flag=0, registered start=0.
REQ-032 Reset asserted mid-RUN SHALL abort the run with no further grants; after release the block SHALL wait for a new start edge.

Structure
REQ-033 The FSM state encodings and FORCE_PIPE_LATENCY SHALL live in the shared package rl_lj_pkg, also used by RL_LJ_Top.
REQ-034 Grant selection and pointer rotation SHALL be one sub-module, rl_lj_rr_arbiter (purely combinational, parameterised by NUM_FILTER); the FSM, counters and output registers stay in the top module.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Start edge with filter_req=4'b1111 held, no stall, for 8 cycles -> grants 0001,0010,0100,1000 repeating; pipe_sel 0,1,2,3 one cycle later; issue_count=8.
- filter_req=4'b1010, pointer at filter 0 -> grant 0010, then 1000, then 0010.
- pipe_stall=1 for 3 cycles mid-run -> filter_grant=0, pointer and issue_count frozen; the sequence resumes at the same filter.
- pair_gen_done=1 and filter_req=0 -> DRAIN for exactly 17 non-stalled cycles, then done=1 and busy=0; a stall of 2 cycles in DRAIN gives done after 19 cycles.
- filter_req=4'b0100 reasserted in DRAIN cycle 5 -> return to RUN, grant 0100, DRAIN re-entered after it clears.
- rst=0 pulse in RUN with issue_count=12 -> all outputs 0 immediately, no grants until the next start edge; start held high from before reset release -> no run.

Source files
------------

// File: rtl/rl_lj_pkg.sv
// Shared definitions for the RL_LJ force pipeline: sizes, latency and the
// filter arbiter FSM encoding.
package rl_lj_pkg;

  localparam int NUM_FILTER         = 4;
  localparam int ARBITER_MSB        = 1 << (NUM_FILTER - 1);
  localparam int FILTER_SEL_WIDTH   = $clog2(NUM_FILTER);
  localparam int FORCE_PIPE_LATENCY = 17;
  localparam int DRAIN_CNT_WIDTH    = $clog2(FORCE_PIPE_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rl_lj_filter_arbiter_if.sv
// Filter-buffer / force-pipeline handshake bundle. The master side is the
// arbiter, the slave side is the buffers plus pipeline input.
interface rl_lj_filter_arbiter_if;
  import rl_lj_pkg::*;

  logic [NUM_FILTER-1:0]       filter_req;
  logic [NUM_FILTER-1:0]       filter_grant;
  logic                        pipe_stall;
  logic                        pipe_input_valid;
  logic [FILTER_SEL_WIDTH-1:0] pipe_sel;

  modport master (
    input  filter_req, pipe_stall,
    output filter_grant, pipe_input_valid, pipe_sel
  );

  modport slave (
    output filter_req, pipe_stall,
    input  filter_grant, pipe_input_valid, pipe_sel
  );

endinterface

// File: rtl/rl_lj_rr_arbiter.sv
// Combinational round-robin selector: first requester at or above the one-hot
// pointer (wrapping), plus the rotated pointer that follows a grant.
module rl_lj_rr_arbiter #(
  parameter int NUM_FILTER = 4,
  parameter int SEL_W      = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1
) (
  input  logic                  en,
  input  logic [NUM_FILTER-1:0] req,
  input  logic [NUM_FILTER-1:0] ptr,
  output logic [NUM_FILTER-1:0] grant,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  grant_valid,
  output logic [NUM_FILTER-1:0] ptr_next
);

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] cand;

  always_comb begin
    base        = '0;
    cand        = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    ptr_next    = ptr;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (ptr[i]) base = SEL_W'(i);
    end
    for (int k = 0; k < NUM_FILTER; k++) begin
      cand = SEL_W'((int'(base) + k) % NUM_FILTER);
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) begin
      ptr_next = '0;
      ptr_next[SEL_W'((int'(grant_idx) + 1) % NUM_FILTER)] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_FILTER; gi++) begin : g_grant
    assign grant[gi] = grant_valid && (grant_idx == SEL_W'(gi));
  end

endmodule

// File: rtl/rl_lj_filter_arbiter.sv
// Shares one force evaluation pipeline among the filter buffers: run/drain
// control FSM, round-robin pop grants and the registered pipeline-input view.
module rl_lj_filter_arbiter
  import rl_lj_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pair_gen_done,
  rl_lj_filter_arbiter_if.master        fif,
  output logic [31:0]                   issue_count,
  output logic                          busy,
  output logic                          done
);

  arb_state_e                  state_q, state_d;
  logic                        start_q, start_d;
  logic                        armed_q, armed_d;
  logic                        pgd_flag_q, pgd_flag_d;
  logic [DRAIN_CNT_WIDTH-1:0]  drain_cnt_q, drain_cnt_d;
  logic [NUM_FILTER-1:0]       ptr_q, ptr_d;
  logic [31:0]                 issue_count_q, issue_count_d;
  logic                        piv_q, piv_d;
  logic [FILTER_SEL_WIDTH-1:0] sel_q, sel_d;

  logic                        start_edge;
  logic                        arb_en;
  logic [NUM_FILTER-1:0]       grant;
  logic [FILTER_SEL_WIDTH-1:0] grant_idx;
  logic                        grant_valid;
  logic [NUM_FILTER-1:0]       ptr_next;

  assign arb_en = (state_q == ST_RUN) && !fif.pipe_stall;

  rl_lj_rr_arbiter #(
    .NUM_FILTER (NUM_FILTER),
    .SEL_W      (FILTER_SEL_WIDTH)
  ) u_rr (
    .en          (arb_en),
    .req         (fif.filter_req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .ptr_next    (ptr_next)
  );

  // armed_q masks the first cycle after reset so a start level already high
  // at release is not mistaken for a fresh request.
  assign start_edge = start && !start_q && armed_q;

  always_comb begin
    state_d       = state_q;
    start_d       = start;
    armed_d       = 1'b1;
    pgd_flag_d    = pgd_flag_q;
    drain_cnt_d   = drain_cnt_q;
    ptr_d         = ptr_q;
    issue_count_d = issue_count_q;
    piv_d         = grant_valid;
    sel_d         = sel_q;

    if (grant_valid) begin
      ptr_d         = ptr_next;
      issue_count_d = sat_inc32(issue_count_q);
      sel_d         = grant_idx;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d       = ST_RUN;
          pgd_flag_d    = 1'b0;
          issue_count_d = '0;
        end
      end
      ST_RUN: begin
        if (pair_gen_done) pgd_flag_d = 1'b1;
        if ((pgd_flag_q || pair_gen_done) && (fif.filter_req == '0)) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (fif.filter_req != '0) begin
          state_d = ST_RUN;
        end else if (!fif.pipe_stall) begin
          if (drain_cnt_q == DRAIN_CNT_WIDTH'(FORCE_PIPE_LATENCY - 1)) state_d = ST_DONE;
          else drain_cnt_d = drain_cnt_q + DRAIN_CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      armed_q       <= 1'b0;
      pgd_flag_q    <= 1'b0;
      drain_cnt_q   <= '0;
      ptr_q         <= NUM_FILTER'(1);
      issue_count_q <= '0;
      piv_q         <= 1'b0;
      sel_q         <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      armed_q       <= armed_d;
      pgd_flag_q    <= pgd_flag_d;
      drain_cnt_q   <= drain_cnt_d;
      ptr_q         <= ptr_d;
      issue_count_q <= issue_count_d;
      piv_q         <= piv_d;
      sel_q         <= sel_d;
    end
  end

  assign fif.filter_grant     = grant;
  assign fif.pipe_input_valid = piv_q;
  assign fif.pipe_sel         = sel_q;
  assign issue_count          = issue_count_q;
  assign busy                 = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done                 = (state_q == ST_DONE);

endmodule

// File: tb/tb_rl_lj_filter_arbiter.sv
// Scenario bench for rl_lj_filter_arbiter: directed scenarios plus a random
// phase, all checked against a rule-level reference model.
module tb_rl_lj_filter_arbiter;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        rst, start, pair_gen_done;
  logic [31:0] issue_count;
  logic        busy, done;

  rl_lj_filter_arbiter_if fif();

  rl_lj_filter_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pair_gen_done (pair_gen_done),
    .fif           (fif),
    .issue_count   (issue_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int          m_state, m_ptr, m_drain, m_sel;
  logic        m_flag, m_piv, m_start_prev;
  logic [31:0] m_cnt;

  logic [3:0]  obs_grant, exp_grant;
  logic        obs_piv, exp_piv, obs_busy, exp_busy, obs_done, exp_done;
  logic [1:0]  obs_sel, exp_sel;
  logic [31:0] obs_cnt, exp_cnt;

  task automatic model_reset();
    m_state = M_IDLE; m_ptr = 0; m_drain = 0; m_sel = 0;
    m_flag = 1'b0; m_piv = 1'b0; m_cnt = '0;
    // a level already high when reset releases does not count as a request
    m_start_prev = 1'b1;
  endtask

  // one clock: drive, sample, predict, then advance the model over the edge
  task automatic run_cycle(input logic [3:0] req, input logic stall,
                           input logic st, input logic pgd);
    int   win;
    logic st_edge;
    @(negedge clk);
    fif.filter_req = req; fif.pipe_stall = stall; start = st; pair_gen_done = pgd;
    #1;
    obs_grant = fif.filter_grant; obs_piv = fif.pipe_input_valid; obs_sel = fif.pipe_sel;
    obs_busy = busy; obs_done = done; obs_cnt = issue_count;

    win = -1;
    if (m_state == M_RUN && !stall)
      for (int k = 0; k < 4; k++)
        if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    exp_grant = (win < 0) ? 4'b0000 : 4'(1 << win);
    exp_piv   = m_piv;
    exp_sel   = 2'(m_sel);
    exp_busy  = (m_state == M_RUN) || (m_state == M_DRAIN);
    exp_done  = (m_state == M_DONE);
    exp_cnt   = m_cnt;

    st_edge = st && !m_start_prev;
    m_start_prev = st;
    m_piv = (win >= 0);
    if (win >= 0) begin
      m_sel = win;
      m_ptr = (win + 1) % 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    case (m_state)
      M_IDLE, M_DONE: if (st_edge) begin m_state = M_RUN; m_flag = 1'b0; m_cnt = 0; end
      M_RUN: begin
        if (pgd) m_flag = 1'b1;
        if (m_flag && req == 4'b0000) begin m_state = M_DRAIN; m_drain = 0; end
      end
      M_DRAIN: begin
        if (req != 4'b0000) m_state = M_RUN;
        else if (!stall) begin
          if (m_drain == LAT - 1) m_state = M_DONE;
          else m_drain = m_drain + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pair_gen_done = 1'b0;
    fif.filter_req = 4'b0000; fif.pipe_stall = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fif.filter_grant !== 4'b0 || fif.pipe_input_valid !== 1'b0 || fif.pipe_sel !== 2'b0 ||
        issue_count !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got grant=%b piv=%b sel=%0d cnt=%0d busy=%b done=%b required all 0",
               fif.filter_grant, fif.pipe_input_valid, fif.pipe_sel, issue_count, busy, done);
    end
    @(negedge clk); rst = 1'b1;
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b grant=%b required 0 0 0000", obs_busy, obs_done, obs_grant);
    end
    $display("test_reset done");
  endtask

  task automatic test_all_req();
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_grant !== 4'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_grant got grant=%b busy=%b required 0000 0", obs_grant, obs_busy);
    end
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_grant !== 4'(1 << (k % 4)) || obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL all_req_grant k=%0d got %b busy=%b required %b busy=1", k, obs_grant, obs_busy, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        checks++;
        if (obs_piv !== 1'b1 || obs_sel !== 2'((k - 1) % 4)) begin
          errors++;
          $display("FAIL all_req_sel k=%0d got piv=%b sel=%0d required 1 %0d", k, obs_piv, obs_sel, (k - 1) % 4);
        end
      end
    end
    run_cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_cnt !== 32'd8 || obs_piv !== 1'b1 || obs_sel !== 2'd3) begin
      errors++;
      $display("FAIL all_req_count got cnt=%0d piv=%b sel=%0d required 8 1 3", obs_cnt, obs_piv, obs_sel);
    end
    $display("test_all_req done cnt=%0d", obs_cnt);
  endtask

  task automatic test_alternate();
    logic [3:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      run_cycle(4'b1010, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_grant !== want[k]) begin
        errors++;
        $display("FAIL alternate_grant k=%0d got %b required %b", k, obs_grant, want[k]);
      end
    end
    $display("test_alternate done");
  endtask

  task automatic test_stall();
    run_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_grant !== 4'b0100) begin
      errors++;
      $display("FAIL stall_pre_grant got %b required 0100", obs_grant);
    end
    for (int k = 0; k < 3; k++) begin
      run_cycle(4'b1111, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_grant !== 4'b0 || obs_cnt !== 32'd12 || obs_piv !== (k == 0)) begin
        errors++;
        $display("FAIL stall_frozen k=%0d got grant=%b cnt=%0d piv=%b required 0000 12 %b",
                 k, obs_grant, obs_cnt, obs_piv, (k == 0));
      end
    end
    run_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_grant !== 4'b1000 || obs_cnt !== 32'd12) begin
      errors++;
      $display("FAIL stall_resume got grant=%b cnt=%0d required 1000 12", obs_grant, obs_cnt);
    end
    run_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_grant !== 4'b0001 || obs_cnt !== 32'd13) begin
      errors++;
      $display("FAIL stall_wrap got grant=%b cnt=%0d required 0001 13", obs_grant, obs_cnt);
    end
    $display("test_stall done");
  endtask

  task automatic test_drain();
    int n;
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (n < 40) begin
      run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      if (obs_done === 1'b1) break;
      n++;
    end
    checks++;
    if (n !== LAT || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_len got %0d cycles busy=%b required %0d busy=0", n, obs_busy, LAT);
    end
    $display("test_drain done cycles=%0d", n);
  endtask

  task automatic test_drain_stall();
    int n;
    run_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_cnt !== 32'd0 || obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got cnt=%0d busy=%b required 0 1", obs_cnt, obs_busy);
    end
    n = 0;
    while (n < 40) begin
      run_cycle(4'b0000, (n == 3 || n == 4), 1'b0, 1'b0);
      if (obs_done === 1'b1) break;
      n++;
    end
    checks++;
    if (n !== LAT + 2) begin
      errors++;
      $display("FAIL drain_stall_len got %0d cycles required %0d", n, LAT + 2);
    end
    $display("test_drain_stall done cycles=%0d", n);
  endtask

  task automatic test_drain_reassert();
    int n;
    run_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    run_cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_grant !== 4'b0 || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL reassert_in_drain got grant=%b busy=%b done=%b required 0000 1 0", obs_grant, obs_busy, obs_done);
    end
    run_cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_grant !== 4'b0100) begin
      errors++;
      $display("FAIL reassert_grant got %b required 0100", obs_grant);
    end
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_piv !== 1'b1 || obs_sel !== 2'd2) begin
      errors++;
      $display("FAIL reassert_sel got piv=%b sel=%0d required 1 2", obs_piv, obs_sel);
    end
    n = 0;
    while (n < 40) begin
      run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      if (obs_done === 1'b1) break;
      n++;
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL reassert_redrain got %0d cycles required %0d", n, LAT);
    end
    $display("test_drain_reassert done cycles=%0d", n);
  endtask

  task automatic test_reset_mid_run();
    int bad;
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_cnt !== 32'd12) begin
      errors++;
      $display("FAIL midrun_count got %0d required 12", obs_cnt);
    end
    @(negedge clk);
    fif.pipe_stall = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (fif.filter_grant !== 4'b0 || fif.pipe_input_valid !== 1'b0 || fif.pipe_sel !== 2'b0 ||
        issue_count !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got grant=%b piv=%b sel=%0d cnt=%0d busy=%b done=%b required all 0",
               fif.filter_grant, fif.pipe_input_valid, fif.pipe_sel, issue_count, busy, done);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
      if (obs_grant !== 4'b0 || obs_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_start_no_run got %0d active cycles required 0", bad);
    end
    run_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_grant !== 4'b0001 || obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start got grant=%b busy=%b required 0001 1", obs_grant, obs_busy);
    end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_random();
    logic [3:0] req;
    logic       stall, st, pgd;
    int         cyc;
    st = 1'b1;
    cyc = 0;
    for (int burst = 0; burst < 10; burst++) begin
      for (int k = 0; k < 55; k++) begin
        req   = (k < 30 && $urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        stall = ($urandom_range(0, 3) == 0);
        pgd   = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 4) == 0) st = ~st;
        run_cycle(req, stall, st, pgd);
        checks++;
        if (obs_grant !== exp_grant) begin
          errors++;
          $display("FAIL rand_grant cyc=%0d got %b required %b", cyc, obs_grant, exp_grant);
        end
        checks++;
        if (obs_piv !== exp_piv || (exp_piv && obs_sel !== exp_sel)) begin
          errors++;
          $display("FAIL rand_pipe cyc=%0d got piv=%b sel=%0d required %b %0d", cyc, obs_piv, obs_sel, exp_piv, exp_sel);
        end
        checks++;
        if (obs_busy !== exp_busy || obs_done !== exp_done || obs_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL rand_status cyc=%0d got busy=%b done=%b cnt=%0d required %b %b %0d",
                   cyc, obs_busy, obs_done, obs_cnt, exp_busy, exp_done, exp_cnt);
        end
        cyc++;
      end
    end
    $display("test_random done cycles=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_alternate();
    test_stall();
    test_drain();
    test_drain_stall();
    test_drain_reassert();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
